// File: rtl/lstm_deskew.sv
// Realigns N staggered lanes (lane i arrives i cycles after lane 0) into whole vectors
// and buffers them in a small FIFO, flagging stagger violations and FIFO overflow.
module lstm_deskew #(
  parameter int unsigned INPUT_BITS_NUM = 16,
  parameter int unsigned NUM_LANES      = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_LANES-1:0]                  in_valid,
  input  logic [NUM_LANES*INPUT_BITS_NUM-1:0]   in_data,
  input  logic                                  clear_err,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [NUM_LANES*INPUT_BITS_NUM-1:0]   out_data,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_count,
  output logic                                  skew_error,
  output logic                                  overflow,
  output logic [15:0]                           vec_count
);

  localparam int unsigned W  = INPUT_BITS_NUM;
  localparam int unsigned N  = NUM_LANES;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  logic [N-1:0]   al_valid;
  logic [N*W-1:0] al_data;

  // Lane 0 pipeline: v0_sr[k] is lane-0 valid delayed k+1 cycles, which also serves
  // as the reference for the stagger check on the other lanes.
  logic [N-2:0] v0_sr;
  logic [W-1:0] d0_sr [N-1];

  always_ff @(posedge clock) begin
    if (!reset) begin
      v0_sr <= '0;
    end else begin
      v0_sr[0] <= in_valid[0];
      for (int unsigned s = 1; s < N-1; s++) v0_sr[s] <= v0_sr[s-1];
    end
  end

  always_ff @(posedge clock) begin
    d0_sr[0] <= in_data[W-1:0];
    for (int unsigned s = 1; s < N-1; s++) d0_sr[s] <= d0_sr[s-1];
  end

  assign al_valid[0]    = v0_sr[N-2];
  assign al_data[W-1:0] = v0_sr[N-2] ? d0_sr[N-2] : '0;

  for (genvar gi = 1; gi < N; gi++) begin : g_lane
    localparam int unsigned D = N - 1 - gi;
    if (D == 0) begin : g_pass
      assign al_valid[gi]       = in_valid[gi];
      assign al_data[gi*W +: W] = in_valid[gi] ? in_data[gi*W +: W] : '0;
    end else begin : g_dly
      logic [D-1:0] v_sr;
      logic [W-1:0] d_sr [D];

      always_ff @(posedge clock) begin
        if (!reset) begin
          v_sr <= '0;
        end else begin
          v_sr[0] <= in_valid[gi];
          for (int unsigned s = 1; s < D; s++) v_sr[s] <= v_sr[s-1];
        end
      end

      always_ff @(posedge clock) begin
        d_sr[0] <= in_data[gi*W +: W];
        for (int unsigned s = 1; s < D; s++) d_sr[s] <= d_sr[s-1];
      end

      // Invalid lanes are zeroed so their don't-care data never reaches the output.
      assign al_valid[gi]       = v_sr[D-1];
      assign al_data[gi*W +: W] = v_sr[D-1] ? d_sr[D-1] : '0;
    end
  end

  logic skew_now;
  assign skew_now = |(in_valid[N-1:1] ^ v0_sr);

  logic [N*W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           push, pop, do_push, drop;

  assign push    = al_valid[0];
  assign pop     = (count != '0) && out_ready;
  assign do_push = push && ((count != DEPTH) || pop);
  assign drop    = push && (count == DEPTH) && !pop;

  always_ff @(posedge clock) begin
    if (reset && do_push) mem[wr_ptr] <= al_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      skew_error <= 1'b0;
      overflow   <= 1'b0;
      vec_count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        vec_count <= vec_count + 16'd1;
      end
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      skew_error <= skew_now | (skew_error & ~clear_err);
      overflow   <= drop     | (overflow   & ~clear_err);
    end
  end

  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

endmodule

// File: tb/tb_lstm_deskew.sv
// Self-checking bench for lstm_deskew: staggered stimulus against a queue-based
// reference model derived from lane arrival history.
module tb_lstm_deskew;
  localparam int N = 4;
  localparam int W = 8;
  localparam int D = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic           clear_err = 1'b0;
  logic           out_ready = 1'b0;
  logic           out_valid;
  logic [N*W-1:0] out_data;
  logic [2:0]     fifo_count;
  logic           skew_error;
  logic           overflow;
  logic [15:0]    vec_count;

  int tests_run = 0;
  int tests_failed = 0;

  lstm_deskew #(.INPUT_BITS_NUM(W), .NUM_LANES(N), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .clear_err(clear_err), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .fifo_count(fifo_count), .skew_error(skew_error),
    .overflow(overflow), .vec_count(vec_count)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [N*W-1:0] d; logic [N*W-1:0] m; } vec_t;
  vec_t           mq[$];
  logic [N-1:0]   hv [N];
  logic [N*W-1:0] hd [N];
  logic           m_skew = 1'b0;
  logic           m_ovf = 1'b0;
  logic [15:0]    m_vc = '0;

  logic [N-1:0]   sv [64];
  logic [N*W-1:0] sd [64];
  int cyc = 0;

  function automatic logic [21:0] exp_status();
    return {mq.size() != 0, 3'(mq.size()), m_skew, m_ovf, m_vc};
  endfunction

  // Reference: vector pushed when lane 0 was valid N-1 samples ago; lane i taken N-1-i samples ago.
  task automatic model_edge();
    vec_t v;
    logic pop, err, drop;
    if (!reset) begin
      mq.delete();
      m_skew = 1'b0; m_ovf = 1'b0; m_vc = '0;
      for (int a = 0; a < N; a++) hv[a] = '0;
      return;
    end
    for (int a = N-1; a > 0; a--) begin hv[a] = hv[a-1]; hd[a] = hd[a-1]; end
    hv[0] = in_valid; hd[0] = in_data;
    err = 1'b0;
    for (int i = 1; i < N; i++) if (hv[0][i] != hv[i][0]) err = 1'b1;
    v.d = '0; v.m = '0;
    for (int i = 0; i < N; i++) begin
      v.d[i*W +: W] = hd[N-1-i][i*W +: W];
      v.m[i*W +: W] = {W{hv[N-1-i][i]}};
    end
    pop = (mq.size() != 0) && out_ready;
    drop = 1'b0;
    if (pop) begin void'(mq.pop_front()); m_vc++; end
    if (hv[N-1][0]) begin
      if (mq.size() < D) mq.push_back(v);
      else drop = 1'b1;
    end
    m_skew = err | (m_skew & ~clear_err);
    m_ovf = drop | (m_ovf & ~clear_err);
  endtask

  task automatic sched_vec(input int off, input logic [N*W-1:0] d, input int late);
    for (int i = 0; i < N; i++) begin
      automatic int s = (cyc + off + i + ((i == late) ? 1 : 0)) % 64;
      sv[s][i] = 1'b1;
      sd[s][i*W +: W] = d[i*W +: W];
    end
  endtask

  task automatic step();
    automatic int idx = cyc % 64;
    in_valid = sv[idx];
    for (int i = 0; i < N; i++)
      in_data[i*W +: W] = sv[idx][i] ? sd[idx][i*W +: W] : W'($urandom);
    sv[idx] = '0;
    @(posedge clock);
    model_edge();
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b0; out_ready = 1'b0; clear_err = 1'b0;
    repeat (2) step();
    tests_run++;
    if ({out_valid, fifo_count, skew_error, overflow, vec_count} !== 22'd0) begin
      tests_failed++;
      $display("FAIL reset_status: got %h want 0", {out_valid, fifo_count, skew_error, overflow, vec_count});
    end
    tests_run++;
    if (out_data !== '0) begin
      tests_failed++; $display("FAIL reset_data: got %h want 0", out_data);
    end
    reset = 1'b1;
  endtask

  task automatic test_single();
    int first = -1;
    out_ready = 1'b1;
    sched_vec(0, 32'h44332211, -1);
    for (int k = 1; k <= 8; k++) begin
      step();
      tests_run++;
      if ({out_valid, fifo_count, skew_error, overflow, vec_count} !== exp_status()) begin
        tests_failed++;
        $display("FAIL single_status k%0d: got %h want %h", k, {out_valid, fifo_count, skew_error, overflow, vec_count}, exp_status());
      end
      if (out_valid === 1'b1 && first < 0) begin
        first = k;
        tests_run++;
        if (out_data !== 32'h44332211) begin
          tests_failed++; $display("FAIL single_data: got %h want 44332211", out_data);
        end
      end
    end
    tests_run++;
    if (first != 4) begin tests_failed++; $display("FAIL single_latency: got %0d want 4", first); end
    tests_run++;
    if (vec_count !== 16'd1) begin tests_failed++; $display("FAIL single_vec_count: got %0d want 1", vec_count); end
  endtask

  task automatic test_back_to_back();
    logic [N*W-1:0] sent [8];
    int got = 0;
    int first = -1;
    int last = -1;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin sent[k] = $urandom; sched_vec(k, sent[k], -1); end
    for (int k = 0; k < 16; k++) begin
      step();
      tests_run++;
      if ({out_valid, fifo_count, skew_error, overflow, vec_count} !== exp_status()) begin
        tests_failed++;
        $display("FAIL b2b_status k%0d: got %h want %h", k, {out_valid, fifo_count, skew_error, overflow, vec_count}, exp_status());
      end
      if (out_valid === 1'b1) begin
        tests_run++;
        if (got >= 8 || out_data !== sent[got]) begin
          tests_failed++; $display("FAIL b2b_data #%0d: got %h", got, out_data);
        end
        if (first < 0) first = k;
        last = k;
        got++;
      end
      tests_run++;
      if (fifo_count > 3'd1) begin tests_failed++; $display("FAIL b2b_count: got %0d want <=1", fifo_count); end
    end
    tests_run++;
    if (got != 8 || last - first != 7) begin
      tests_failed++; $display("FAIL b2b_burst: got %0d vectors over %0d cycles want 8 over 8", got, last - first + 1);
    end
  endtask

  task automatic test_overflow();
    logic [N*W-1:0] sent [6];
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin sent[k] = $urandom; sched_vec(k, sent[k], -1); end
    repeat (10) begin
      step();
      tests_run++;
      if ({out_valid, fifo_count, skew_error, overflow, vec_count} !== exp_status()) begin
        tests_failed++;
        $display("FAIL ovf_status: got %h want %h", {out_valid, fifo_count, skew_error, overflow, vec_count}, exp_status());
      end
    end
    tests_run++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
      tests_failed++; $display("FAIL ovf_full: got count %0d ovf %b want 4 1", fifo_count, overflow);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== sent[k]) begin
        tests_failed++; $display("FAIL ovf_drain #%0d: got %b %h want 1 %h", k, out_valid, out_data, sent[k]);
      end
      step();
    end
    repeat (3) step();
    tests_run++;
    if (out_valid !== 1'b0 || vec_count !== m_vc) begin
      tests_failed++; $display("FAIL ovf_lost: got valid %b vec_count %0d want 0 %0d", out_valid, vec_count, m_vc);
    end
    clear_err = 1'b1; step(); clear_err = 1'b0;
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_skew();
    out_ready = 1'b1;
    sched_vec(0, $urandom, 2);
    for (int k = 1; k <= 8; k++) begin
      clear_err = (k == 4 || k == 5);
      step();
      tests_run++;
      if ({out_valid, fifo_count, skew_error, overflow, vec_count} !== exp_status()) begin
        tests_failed++;
        $display("FAIL skew_status k%0d: got %h want %h", k, {out_valid, fifo_count, skew_error, overflow, vec_count}, exp_status());
      end
      if (k >= 3 && k <= 5) begin
        tests_run++;
        if (skew_error !== (k != 5)) begin
          tests_failed++; $display("FAIL skew_flag k%0d: got %b want %b", k, skew_error, k != 5);
        end
      end
    end
    clear_err = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [N*W-1:0] sent [8];
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin sent[k] = $urandom; sched_vec(k, sent[k], -1); end
    repeat (7) step();
    tests_run++;
    if (fifo_count !== 3'd4) begin tests_failed++; $display("FAIL fpp_fill: got %0d want 4", fifo_count); end
    for (int k = 4; k < 8; k++) begin sent[k] = $urandom; sched_vec(k - 4, sent[k], -1); end
    for (int k = 1; k <= 7; k++) begin
      out_ready = (k >= 4);
      if (k >= 4) begin
        tests_run++;
        if (out_data !== sent[k-4]) begin
          tests_failed++; $display("FAIL fpp_head k%0d: got %h want %h", k, out_data, sent[k-4]);
        end
      end
      step();
      if (k >= 4) begin
        tests_run++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
          tests_failed++; $display("FAIL fpp_hold k%0d: got count %0d ovf %b want 4 0", k, fifo_count, overflow);
        end
      end
    end
    out_ready = 1'b1;
    for (int k = 4; k < 8; k++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== sent[k]) begin
        tests_failed++; $display("FAIL fpp_drain #%0d: got %b %h want 1 %h", k, out_valid, out_data, sent[k]);
      end
      step();
    end
    tests_run++;
    if ({out_valid, fifo_count, skew_error, overflow, vec_count} !== exp_status()) begin
      tests_failed++;
      $display("FAIL fpp_end: got %h want %h", {out_valid, fifo_count, skew_error, overflow, vec_count}, exp_status());
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 1) == 1)
        sched_vec(0, $urandom, ($urandom_range(0, 15) == 0) ? 1 + int'($urandom_range(0, 2)) : -1);
      out_ready = ($urandom_range(0, 3) != 0);
      clear_err = ($urandom_range(0, 7) == 0);
      step();
      tests_run++;
      if ({out_valid, fifo_count, skew_error, overflow, vec_count} !== exp_status()) begin
        tests_failed++;
        $display("FAIL rand_status k%0d: got %h want %h", k, {out_valid, fifo_count, skew_error, overflow, vec_count}, exp_status());
      end
      if (out_valid === 1'b1 && mq.size() != 0) begin
        tests_run++;
        if ((out_data & mq[0].m) !== (mq[0].d & mq[0].m)) begin
          tests_failed++; $display("FAIL rand_data k%0d: got %h want %h", k, out_data & mq[0].m, mq[0].d & mq[0].m);
        end
      end
    end
    clear_err = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();
  endtask

  task automatic test_mid_reset();
    clear_err = 1'b1; step(); clear_err = 1'b0;
    out_ready = 1'b0;
    sched_vec(0, $urandom, -1);
    sched_vec(1, $urandom, -1);
    repeat (5) step();
    tests_run++;
    if (fifo_count !== 3'd2) begin tests_failed++; $display("FAIL mrst_pre: got %0d want 2", fifo_count); end
    sched_vec(0, $urandom, -1);
    sched_vec(1, $urandom, -1);
    repeat (2) step();
    reset = 1'b0;
    step();
    for (int s = 0; s < 64; s++) sv[s] = '0;
    tests_run++;
    if ({out_valid, fifo_count, skew_error, overflow, vec_count, out_data} !== '0) begin
      tests_failed++;
      $display("FAIL mrst_outputs: got %h %h want 0", {out_valid, fifo_count, skew_error, overflow, vec_count}, out_data);
    end
    reset = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      tests_run++;
      if (out_valid !== 1'b0 || skew_error !== 1'b0 || fifo_count !== 3'd0) begin
        tests_failed++;
        $display("FAIL mrst_after k%0d: got valid %b skew %b count %0d want 0 0 0", k, out_valid, skew_error, fifo_count);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < N; a++) begin hv[a] = '0; hd[a] = '0; end
    for (int s = 0; s < 64; s++) begin sv[s] = '0; sd[s] = '0; end
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_skew();
    test_full_push_pop();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
